// File: rtl/buffer_word_reader.sv
// buffer_word_reader: drain side of the bootloader byte buffer.
// Pops bytes from the buffer, packs them MSB-first into OUT_WIDTH words and
// offers each word on a valid/ready port. A partial word that stalls for
// TIMEOUT_CYCLES is dropped. Optional sync-word hunt: `BUFFER_WORD_READER_SYNC_EN.
module buffer_word_reader #(
  parameter int unsigned          WORD_WIDTH     = 8,
  parameter int unsigned          OUT_WIDTH      = 32,
  parameter logic [OUT_WIDTH-1:0] SYNC_WORD      = 32'hFAB0_FAB1,
  parameter logic [15:0]          TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WORD_WIDTH-1:0] data_in_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [OUT_WIDTH-1:0]  data_out_o,
  output logic                  sync_o,
  output logic                  timeout_o
);

  localparam int unsigned      N        = OUT_WIDTH / WORD_WIDTH;
  localparam int unsigned      IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  // Timeout fires on the idle cycle that would bring the counter to TIMEOUT_CYCLES-1.
  localparam logic [15:0]      TMO_LAST = TIMEOUT_CYCLES - 16'd2;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_HOLD    = 2'd1,
    S_HUNT    = 2'd2
  } state_t;

`ifdef BUFFER_WORD_READER_SYNC_EN
  localparam state_t RESET_STATE = S_HUNT;
`else
  localparam state_t RESET_STATE = S_COLLECT;
`endif

  // Elaboration-time sanity check of the parameter set.
  if (((OUT_WIDTH % WORD_WIDTH) != 0) || (N < 2) || (TIMEOUT_CYCLES < 16'd2) ||
      ($bits(SYNC_WORD) != OUT_WIDTH)) begin : g_param_check
    $error("buffer_word_reader: invalid parameter set");
  end

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]  collect_q, collect_d;
  logic [OUT_WIDTH-1:0]  dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  tmo_q, tmo_d;
  logic                  ready_int;
  logic                  accept;
`ifdef BUFFER_WORD_READER_SYNC_EN
  logic                  sync_q, sync_d;
  logic [OUT_WIDTH-1:0]  shreg_q, shreg_d;
`endif

  assign ready_int   = en_i && (state_q != S_HOLD);
  assign in_ready_o  = ready_int && !rst_i;
  assign accept      = in_valid_i && ready_int;
  assign out_valid_o = valid_q;
  assign data_out_o  = dout_q;
  assign timeout_o   = tmo_q;
`ifdef BUFFER_WORD_READER_SYNC_EN
  assign sync_o      = sync_q;
`else
  assign sync_o      = 1'b1;
`endif

  // Next-state logic: hunt, byte packing, word hand-off and idle timeout.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    collect_d = collect_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    tmo_d     = 1'b0;
`ifdef BUFFER_WORD_READER_SYNC_EN
    sync_d    = sync_q;
    shreg_d   = shreg_q;
`endif
    case (state_q)
`ifdef BUFFER_WORD_READER_SYNC_EN
      S_HUNT: begin
        if (accept) begin
          shreg_d = {shreg_q[OUT_WIDTH-WORD_WIDTH-1:0], data_in_i};
          if (shreg_d == SYNC_WORD) begin
            sync_d  = 1'b1;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_COLLECT;
          end
        end
      end
`endif
      S_COLLECT: begin
        if (accept) begin
          for (int unsigned b = 0; b < N; b++) begin
            if (idx_q == IDX_W'(b)) begin
              collect_d[OUT_WIDTH-1-b*WORD_WIDTH -: WORD_WIDTH] = data_in_i;
            end
          end
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            dout_d  = collect_d;
            valid_d = 1'b1;
            idx_d   = '0;
            state_d = S_HOLD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (en_i && (idx_q != '0)) begin
          if (cnt_q == TMO_LAST) begin
            idx_d     = '0;
            cnt_d     = '0;
            collect_d = '0;
            tmo_d     = 1'b1;
`ifdef BUFFER_WORD_READER_SYNC_EN
            sync_d    = 1'b0;
            shreg_d   = '0;
            state_d   = S_HUNT;
`endif
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_HOLD: begin
        // The held word may be taken even while en_i is low.
        if (valid_q && out_ready_i) begin
          valid_d = 1'b0;
          state_d = S_COLLECT;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // State register; en_i low freezes everything except the hold hand-off.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RESET_STATE;
      idx_q     <= '0;
      cnt_q     <= '0;
      collect_q <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      tmo_q     <= 1'b0;
`ifdef BUFFER_WORD_READER_SYNC_EN
      sync_q    <= 1'b0;
      shreg_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      collect_q <= collect_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      tmo_q     <= tmo_d;
`ifdef BUFFER_WORD_READER_SYNC_EN
      sync_q    <= sync_d;
      shreg_q   <= shreg_d;
`endif
    end
  end

endmodule

// File: tb/tb_buffer_word_reader.sv
// tb_buffer_word_reader: table-driven, directed and randomized checks of
// buffer_word_reader against a queue-based reference model.
module tb_buffer_word_reader;

`ifdef BUFFER_WORD_READER_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
  localparam int          TMO  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        iv = 1'b0;
  logic [7:0]  din = '0;
  logic        ordy = 1'b0;
  logic        in_ready_o, out_valid_o, sync_o, timeout_o;
  logic [31:0] data_out_o;

  buffer_word_reader #(
    .WORD_WIDTH(8),
    .OUT_WIDTH(32),
    .SYNC_WORD(32'hFAB0_FAB1),
    .TIMEOUT_CYCLES(16'd8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .en_i(en),
    .in_valid_i(iv),
    .in_ready_o(in_ready_o),
    .data_in_i(din),
    .out_valid_o(out_valid_o),
    .out_ready_i(ordy),
    .data_out_o(data_out_o),
    .sync_o(sync_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit last_acc;

  // Reference model state
  logic [7:0]  m_bytes[$];
  logic [31:0] m_word;
  logic [31:0] m_hist;
  bit          m_hold, m_sync, m_tmo;
  int          m_idle;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_bytes.delete();
    m_word = '0;
    m_hist = '0;
    m_hold = 1'b0;
    m_sync = !SYNC_EN;
    m_tmo  = 1'b0;
    m_idle = 0;
  endfunction

  function automatic void model_step();
    bit acc;
    if (rst) begin
      model_reset();
      return;
    end
    m_tmo = 1'b0;
    acc = en && iv && !m_hold;
    if (m_hold) begin
      if (ordy) m_hold = 1'b0;
    end else if (!m_sync) begin
      if (acc) begin
        m_hist = {m_hist[23:0], din};
        if (m_hist == SYNC) begin
          m_sync = 1'b1;
          m_bytes.delete();
          m_idle = 0;
        end
      end
    end else if (acc) begin
      m_bytes.push_back(din);
      m_idle = 0;
      if (m_bytes.size() == 4) begin
        m_word = '0;
        foreach (m_bytes[i]) m_word = (m_word << 8) | 32'(m_bytes[i]);
        m_hold = 1'b1;
        m_bytes.delete();
      end
    end else if (en && m_bytes.size() != 0) begin
      m_idle++;
      if (m_idle == TMO - 1) begin
        m_tmo = 1'b1;
        m_bytes.delete();
        m_idle = 0;
        if (SYNC_EN) begin
          m_sync = 1'b0;
          m_hist = '0;
        end
      end
    end
  endfunction

  // One clock cycle with the currently driven inputs, checked against the model.
  task automatic tick();
    #1;
    check("in_ready", 64'(in_ready_o), 64'(!rst && en && !m_hold));
    last_acc = in_ready_o && iv;
    model_step();
    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid_o), 64'(m_hold));
    check("timeout", 64'(timeout_o), 64'(m_tmo));
    check("sync", 64'(sync_o), 64'(m_sync));
    if (m_hold) check("data_out", 64'(data_out_o), 64'(m_word));
  endtask

  task automatic feed(input logic [7:0] b);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    iv = 1'b1;
    din = b;
    while (!acc && n < 20) begin
      tick();
      acc = last_acc;
      n++;
    end
    iv = 1'b0;
    if (!acc) check("feed_accept_bound", 64'd0, 64'd1);
  endtask

  task automatic expect_word(input string name, input logic [31:0] w);
    check({name, "_valid"}, 64'(out_valid_o), 64'd1);
    check({name, "_data"}, 64'(data_out_o), 64'(w));
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
  endtask

  task automatic sync_up();
    if (SYNC_EN) begin
      feed(8'hFA); feed(8'hB0); feed(8'hFA); feed(8'hB1);
      check("sync_up", 64'(sync_o), 64'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        en, iv;
    logic [7:0]  din;
    logic        ordy;
    logic        exp_rdy, exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic v, input logic [7:0] d, input logic r,
                              input logic xr, input logic xv, input logic [31:0] xd);
    vec_t t;
    t.en = e; t.iv = v; t.din = d; t.ordy = r;
    t.exp_rdy = xr; t.exp_valid = xv; t.exp_data = xd;
    return t;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[15];
    logic [31:0] words[10];
    int          wcyc[10];
    int          nw, ptr, first, pulses;

    tbl[0] = mk(1, 1, 8'h01, 0, 1, 0, 32'h0);
    tbl[1] = mk(1, 1, 8'h02, 0, 1, 0, 32'h0);
    tbl[2] = mk(1, 1, 8'h03, 0, 1, 0, 32'h0);
    tbl[3] = mk(1, 1, 8'h04, 0, 1, 1, 32'h01020304);
    for (int i = 4; i < 9; i++) tbl[i] = mk(1, 1, 8'h05, 0, 0, 1, 32'h01020304);
    tbl[9]  = mk(1, 1, 8'h05, 1, 0, 0, 32'h0);
    tbl[10] = mk(1, 1, 8'h05, 0, 1, 0, 32'h0);
    tbl[11] = mk(1, 1, 8'h06, 0, 1, 0, 32'h0);
    tbl[12] = mk(1, 1, 8'h07, 0, 1, 0, 32'h0);
    tbl[13] = mk(1, 1, 8'h08, 0, 1, 1, 32'h05060708);
    tbl[14] = mk(1, 0, 8'h00, 1, 0, 0, 32'h0);

    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    en = 1'b1;

    // Reset asserted mid-word
    sync_up();
    feed(8'hA1);
    feed(8'hA2);
    rst = 1'b1;
    model_reset();
    #2;
    check("rst_in_ready", 64'(in_ready_o), 64'd0);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_data_out", 64'(data_out_o), 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);
    check("rst_sync", 64'(sync_o), 64'(!SYNC_EN));
    tick();
    rst = 1'b0;
    sync_up();
    feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
    expect_word("after_reset", 32'h11223344);

`ifdef BUFFER_WORD_READER_SYNC_EN
    // Sync hunt: only the word after the marker is emitted
    do_reset();
    nw = 0;
    feed(8'hAA); feed(8'hFA); feed(8'hB0); feed(8'hFA);
    check("hunt_presync", 64'(sync_o), 64'd0);
    if (out_valid_o) nw++;
    feed(8'hB1);
    check("hunt_sync_rise", 64'(sync_o), 64'd1);
    if (out_valid_o) nw++;
    feed(8'hDE); feed(8'hAD); feed(8'hBE);
    if (out_valid_o) nw++;
    check("hunt_no_early_word", 64'(nw), 64'd0);
    feed(8'hEF);
    expect_word("hunt_word", 32'hDEADBEEF);
`endif

    // Pack and backpressure table
    for (int i = 0; i < 15; i++) begin
      en = tbl[i].en; iv = tbl[i].iv; din = tbl[i].din; ordy = tbl[i].ordy;
      #1;
      check($sformatf("tbl%0d_rdy", i), 64'(in_ready_o), 64'(tbl[i].exp_rdy));
      tick();
      check($sformatf("tbl%0d_valid", i), 64'(out_valid_o), 64'(tbl[i].exp_valid));
      if (tbl[i].exp_valid)
        check($sformatf("tbl%0d_data", i), 64'(data_out_o), 64'(tbl[i].exp_data));
    end
    iv = 1'b0; ordy = 1'b0; en = 1'b1;

    // Back-to-back: 40 bytes, 10 words, spaced N+1 cycles
    nw = 0; ptr = 0; ordy = 1'b1;
    for (int c = 0; c < 100 && nw < 10; c++) begin
      din = 8'(8'h10 + ptr);
      iv = (ptr < 40);
      tick();
      if (last_acc) ptr++;
      if (out_valid_o) begin
        words[nw] = data_out_o;
        wcyc[nw] = c;
        nw++;
      end
    end
    iv = 1'b0;
    tick();
    ordy = 1'b0;
    check("b2b_word_count", 64'(nw), 64'd10);
    for (int w = 0; w < nw; w++) begin
      check($sformatf("b2b_word%0d", w), 64'(words[w]),
            64'({8'(16 + 4*w), 8'(17 + 4*w), 8'(18 + 4*w), 8'(19 + 4*w)}));
      if (w > 0) check($sformatf("b2b_gap%0d", w), 64'(wcyc[w] - wcyc[w-1]), 64'd5);
    end

    // Timeout: 2 bytes then idle
    feed(8'h5A); feed(8'h5B);
    first = 0; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (timeout_o) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("timeout_delay", 64'(first), 64'd7);
    check("timeout_pulses", 64'(pulses), 64'd1);
    check("timeout_sync", 64'(sync_o), 64'(!SYNC_EN));
    sync_up();
    feed(8'h61); feed(8'h62); feed(8'h63); feed(8'h64);
    expect_word("post_timeout", 32'h61626364);

    // Enable freeze between bytes 2 and 3
    feed(8'hC1); feed(8'hC2);
    en = 1'b0; iv = 1'b1; din = 8'hC3; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (timeout_o) pulses++;
    end
    check("freeze_no_timeout", 64'(pulses), 64'd0);
    en = 1'b1;
    feed(8'hC3); feed(8'hC4);
    expect_word("freeze_word", 32'hC1C2C3C4);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 499) == 0);
      en   = ($urandom_range(0, 9) != 0);
      iv   = ((i / 200) % 2 == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 1);
      ordy = ($urandom_range(0, 9) < 6);
      din  = 8'($urandom);
      tick();
    end
    rst = 1'b0; iv = 1'b0; ordy = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
